// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and default geometry for the systolic array controller
package systolic_pkg;
   localparam int SA_N       = 3;
   localparam int SA_DATA_W  = 8;
   localparam int SA_ACC_W   = 16;
   localparam int SA_TIMEOUT = 12;
   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences one 3x3 matrix job into a systolic array, waits for its result with a timeout, and hands the result off
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N       = SA_N,
   parameter int DATA_W  = SA_DATA_W,
   parameter int ACC_W   = SA_ACC_W,
   parameter int TIMEOUT = SA_TIMEOUT
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start_valid,
   output logic                    o_start_ready,
   input  logic [N*N*DATA_W-1:0]   i_mat_a,
   input  logic [N*N*DATA_W-1:0]   i_mat_b,
   output logic                    o_sa_rst_n,
   output logic [N*DATA_W-1:0]     o_sa_A,
   output logic [N*DATA_W-1:0]     o_sa_B,
   input  logic [N*N*ACC_W-1:0]    i_sa_C,
   input  logic                    i_sa_C_valid,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [N*N*ACC_W-1:0]    o_res_C,
   output logic                    o_timeout
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   state_t                r_state, w_state;
   logic [1:0]            r_k, w_k;
   logic [CNT_W-1:0]      r_cnt, w_cnt;
   logic [N*N*DATA_W-1:0] r_a, r_b, w_a, w_b;
   logic [N*DATA_W-1:0]   w_sa_a, w_sa_b;
   logic [N*N*ACC_W-1:0]  w_res_c;
   logic                  w_res_valid, w_timeout, w_feed;
   always_comb begin
      w_state     = r_state;
      w_k         = r_k;
      w_cnt       = r_cnt;
      w_a         = r_a;
      w_b         = r_b;
      w_res_c     = o_res_C;
      w_res_valid = o_res_valid;
      w_timeout   = 1'b0;
      w_feed      = 1'b0;
      w_sa_a      = '0;
      w_sa_b      = '0;
      case (r_state)
         S_IDLE: if (i_start_valid && o_start_ready) begin
            w_state = S_FEED;
            w_k     = 2'd0;
            w_cnt   = '0;
            w_a     = i_mat_a;
            w_b     = i_mat_b;
            w_feed  = 1'b1;
         end
         S_FEED: if (r_k == 2'(N - 1)) begin
            w_state = S_DRAIN;
            w_cnt   = '0;
         end else begin
            w_k    = r_k + 2'd1;
            w_feed = 1'b1;
         end
         // the final DRAIN cycle is the abort cycle announced by o_timeout
         S_DRAIN: if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_state = S_IDLE;
         end else if (i_sa_C_valid) begin
            w_state     = S_DONE;
            w_res_c     = i_sa_C;
            w_res_valid = 1'b1;
         end else begin
            w_cnt     = r_cnt + 1'b1;
            w_timeout = (r_cnt == CNT_W'(TIMEOUT - 2));
         end
         S_DONE: if (i_res_ready) begin
            w_state     = S_IDLE;
            w_res_valid = 1'b0;
         end
         default: w_state = S_IDLE;
      endcase
      for (int r = 0; r < N; r++) begin
         w_sa_a[r*DATA_W +: DATA_W] = w_feed ? w_a[(r*N + int'(w_k))*DATA_W +: DATA_W] : '0;
         w_sa_b[r*DATA_W +: DATA_W] = w_feed ? w_b[(int'(w_k)*N + r)*DATA_W +: DATA_W] : '0;
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_k           <= '0;
         r_cnt         <= '0;
         r_a           <= '0;
         r_b           <= '0;
         o_start_ready <= 1'b0;
         o_sa_rst_n    <= 1'b0;
         o_sa_A        <= '0;
         o_sa_B        <= '0;
         o_res_valid   <= 1'b0;
         o_res_C       <= '0;
         o_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_k           <= w_k;
         r_cnt         <= w_cnt;
         r_a           <= w_a;
         r_b           <= w_b;
         o_start_ready <= (w_state == S_IDLE);
         o_sa_rst_n    <= (w_state == S_FEED) || (w_state == S_DRAIN);
         o_sa_A        <= w_sa_a;
         o_sa_B        <= w_sa_b;
         o_res_valid   <= w_res_valid;
         o_res_C       <= w_res_c;
         o_timeout     <= w_timeout;
      end
   end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized jobs against a matrix-level reference of feed order, result capture and timeout
module tb_systolic_ctrl;
   logic         i_clk = 1'b0, i_rst = 1'b1;
   logic         i_start_valid = 1'b0, i_sa_C_valid = 1'b0, i_res_ready = 1'b0;
   logic [71:0]  i_mat_a = '0, i_mat_b = '0;
   logic [143:0] i_sa_C = '0;
   logic         o_start_ready, o_sa_rst_n, o_res_valid, o_timeout;
   logic [23:0]  o_sa_A, o_sa_B;
   logic [143:0] o_res_C;
   int           n_vec = 0, n_err = 0;
   int           ma [3][3];
   int           mb [3][3];
   logic [143:0] last_c = '0;

   always #5 i_clk = ~i_clk;

   systolic_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
      .i_mat_a(i_mat_a), .i_mat_b(i_mat_b), .o_sa_rst_n(o_sa_rst_n), .o_sa_A(o_sa_A), .o_sa_B(o_sa_B),
      .i_sa_C(i_sa_C), .i_sa_C_valid(i_sa_C_valid), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_C(o_res_C), .o_timeout(o_timeout)
   );

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [71:0] pack_m(input bit is_b);
      logic [71:0] v;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            v[(r*3+c)*8 +: 8] = 8'(is_b ? mb[r][c] : ma[r][c]);
      return v;
   endfunction

   function automatic logic [23:0] col_a(input int k);
      logic [23:0] v;
      for (int r = 0; r < 3; r++) v[r*8 +: 8] = 8'(ma[r][k]);
      return v;
   endfunction

   function automatic logic [23:0] row_b(input int k);
      logic [23:0] v;
      for (int c = 0; c < 3; c++) v[c*8 +: 8] = 8'(mb[k][c]);
      return v;
   endfunction

   function automatic logic [143:0] prod();
      logic [143:0] v;
      int s;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int k = 0; k < 3; k++) s += ma[r][k] * mb[k][c];
            v[(r*3+c)*16 +: 16] = 16'(s);
         end
      return v;
   endfunction

   function automatic logic [143:0] rnd144();
      logic [143:0] v;
      for (int i = 0; i < 9; i++) v[i*16 +: 16] = 16'($urandom);
      return v;
   endfunction

   function automatic logic [71:0] rnd72();
      return {8'($urandom), 32'($urandom), 32'($urandom)};
   endfunction

   task automatic rand_mats;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[r][c] = $urandom_range(0, 255);
            mb[r][c] = $urandom_range(0, 255);
         end
   endtask

   // lat = DRAIN cycle (1..11) carrying the array result, 0 = never; rdly = DONE cycles before ready
   task automatic run_job(input int lat, input int rdly);
      logic [143:0] c;
      c = prod();
      chk("idle_ready", o_start_ready, 1);
      i_mat_a = pack_m(0);
      i_mat_b = pack_m(1);
      i_start_valid = 1'b1;
      tick;
      i_start_valid = 1'b0;
      i_mat_a = rnd72();
      i_mat_b = rnd72();
      for (int k = 0; k < 3; k++) begin
         chk("feed_a", o_sa_A, col_a(k));
         chk("feed_b", o_sa_B, row_b(k));
         chk("feed_rstn", o_sa_rst_n, 1);
         chk("feed_ready", o_start_ready, 0);
         i_sa_C_valid = 1'($urandom_range(0, 1));
         i_sa_C = rnd144();
         tick;
      end
      for (int d = 1; d <= 12; d++) begin
         chk("drain_feed", {o_sa_A, o_sa_B}, 0);
         chk("drain_rstn", o_sa_rst_n, 1);
         chk("drain_valid", o_res_valid, 0);
         chk("drain_timeout", o_timeout, d == 12);
         i_sa_C_valid = (d == lat);
         i_sa_C = (d == lat) ? c : rnd144();
         tick;
         i_sa_C_valid = 1'b0;
         if (d == lat) break;
      end
      if (lat == 0) begin
         chk("to_ready", o_start_ready, 1);
         chk("to_pulse_end", o_timeout, 0);
         chk("to_no_valid", o_res_valid, 0);
         chk("to_res_kept", o_res_C, last_c);
      end else begin
         last_c = c;
         for (int w = 0; w <= rdly; w++) begin
            chk("done_valid", o_res_valid, 1);
            chk("done_c", o_res_C, c);
            chk("done_ready", o_start_ready, 0);
            chk("done_rstn", o_sa_rst_n, 0);
            i_res_ready = (w == rdly);
            i_sa_C_valid = 1'($urandom_range(0, 1));
            i_sa_C = rnd144();
            tick;
         end
         i_res_ready = 1'b0;
         i_sa_C_valid = 1'b0;
         chk("post_valid", o_res_valid, 0);
         chk("post_ready", o_start_ready, 1);
         chk("post_rstn", o_sa_rst_n, 0);
      end
   endtask

   initial begin
      #2;
      chk("rst_ctl", {o_start_ready, o_sa_rst_n, o_res_valid, o_timeout, o_sa_A, o_sa_B}, 0);
      chk("rst_res", o_res_C, 0);
      tick;
      tick;
      i_rst = 1'b0;
      chk("rst_ready_hold", o_start_ready, 0);
      tick;
      // identity times [1..9] returns B
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[r][c] = (r == c);
            mb[r][c] = r*3 + c + 1;
         end
      chk("ident_model", prod(), {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
      run_job($urandom_range(1, 11), 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[r][c] = 1;
            mb[r][c] = 2;
         end
      chk("ones_feed_model", {col_a(0), row_b(0)}, {24'h010101, 24'h020202});
      run_job(1, 0);
      chk("ones_result", o_res_C, {9{16'd6}});
      rand_mats();
      run_job(0, 0);
      rand_mats();
      run_job(11, 5);
      rand_mats();
      run_job(2, 0);
      rand_mats();
      run_job(3, 0);
      for (int j = 0; j < 20; j++) begin
         rand_mats();
         run_job($urandom_range(0, 11), $urandom_range(0, 3));
      end
      // reset in FEED step k=1
      rand_mats();
      i_mat_a = pack_m(0);
      i_mat_b = pack_m(1);
      i_start_valid = 1'b1;
      tick;
      i_start_valid = 1'b0;
      tick;
      chk("pre_rst_feed", o_sa_A, col_a(1));
      #1 i_rst = 1'b1;
      #1;
      chk("mid_rst_ctl", {o_start_ready, o_sa_rst_n, o_res_valid, o_timeout, o_sa_A, o_sa_B}, 0);
      chk("mid_rst_res", o_res_C, 0);
      i_rst = 1'b0;
      last_c = '0;
      tick;
      chk("post_rst_ready", o_start_ready, 1);
      for (int i = 0; i < 15; i++) begin
         i_sa_C_valid = 1'($urandom_range(0, 1));
         i_sa_C = rnd144();
         tick;
         chk("abandon_quiet", {o_res_valid, o_timeout, o_sa_rst_n}, 0);
      end
      i_sa_C_valid = 1'b0;
      rand_mats();
      run_job(0, 0);
      rand_mats();
      run_job(5, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
